// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending CPU stores that drains to data
// memory one entry per cycle whenever the memory port is free.
// Optional store-to-load forwarding is compiled in when the macro
// STORE_BUF_FWD_EN is defined; without it ld_hit/ld_data are tied to 0.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     st_valid,
  input  logic [DW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic [DW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  input  logic                     mem_busy,
  output logic                     WE,
  output logic [DW-1:0]            A_DM,
  output logic [DW-1:0]            WD,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] addrMem_q [DEPTH];
  logic [DW-1:0] dataMem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          notEmpty;
  logic          doPush;
  logic          doDrain;

  // Handshake decode: full blocks pushes even if a drain happens this cycle.
  always_comb begin
    full     = (count_q == FULL_CNT);
    notEmpty = (count_q != '0);
    doPush   = st_valid && !full;
    doDrain  = notEmpty && !mem_busy;
  end

  // Pointer, occupancy and overflow next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (doPush)  tail_d = tail_q + 1'b1;
    if (doDrain) head_d = head_q + 1'b1;
    if (doPush && !doDrain)      count_d = count_q + 1'b1;
    else if (!doPush && doDrain) count_d = count_q - 1'b1;
    if (st_valid && full) ovf_d = 1'b1;
  end

  // Control registers, cleared immediately by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry storage: written at the tail on a push, wiped on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        addrMem_q[i] <= '0;
        dataMem_q[i] <= '0;
      end
    end else if (doPush) begin
      addrMem_q[tail_q] <= st_addr;
      dataMem_q[tail_q] <= st_data;
    end
  end

  // Memory-side outputs show the head entry, zero when empty.
  always_comb begin
    st_ready = !full;
    count    = count_q;
    ovf_err  = ovf_q;
    WE       = doDrain;
    A_DM     = notEmpty ? addrMem_q[head_q] : '0;
    WD       = notEmpty ? dataMem_q[head_q] : '0;
  end

`ifdef STORE_BUF_FWD_EN
  logic [AW-1:0] fwdIdx;

  // Forwarding search from oldest to youngest so the youngest match wins.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwdIdx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwdIdx = head_q + AW'(i);
      if ((CW'(i) < count_q) && (addrMem_q[fwdIdx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = dataMem_q[fwdIdx];
      end
    end
  end
`else
  logic unusedLdAddr;

  // Forwarding disabled: load lookups never hit.
  always_comb begin
    ld_hit       = 1'b0;
    ld_data      = '0;
    unusedLdAddr = ^ld_addr;
  end
`endif

endmodule
